// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and the data stage.
// Data has priority; a burst counter guarantees fetch a slot after DATA_BURST_MAX data grants.
`default_nettype none
`timescale 1ns/1ps

module mem_arbiter #(
   parameter int DATA_BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        ireq_valid,
   input  logic [63:0] ireq_addr,
   output logic        iresp_ok,
   output logic [31:0] iresp_data,

   input  logic        dreq_valid,
   input  logic        dreq_write,
   input  logic [63:0] dreq_addr,
   input  logic [2:0]  dreq_size,
   input  logic [63:0] dreq_data,
   input  logic [7:0]  dreq_strobe,
   output logic        dresp_ok,
   output logic [63:0] dresp_data,

   output logic        bus_valid,
   output logic        bus_write,
   output logic [63:0] bus_addr,
   output logic [2:0]  bus_size,
   output logic [63:0] bus_data,
   output logic [7:0]  bus_strobe,
   input  logic        bus_ready,
   input  logic        bus_rvalid,
   input  logic [63:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

   state_t     state;
   logic       own_d;
   logic [3:0] dcnt;
   logic       data_wins;

   // Fetch only overrides data once data has used up its burst allowance.
   assign data_wins = dreq_valid && !(ireq_valid && (dcnt == BURST_MAX));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         own_d      <= 1'b0;
         dcnt       <= 4'd0;
         bus_valid  <= 1'b0;
         bus_write  <= 1'b0;
         bus_addr   <= 64'd0;
         bus_size   <= 3'd0;
         bus_data   <= 64'd0;
         bus_strobe <= 8'd0;
         iresp_ok   <= 1'b0;
         iresp_data <= 32'd0;
         dresp_ok   <= 1'b0;
         dresp_data <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (ireq_valid || dreq_valid) begin
                  state     <= REQ;
                  bus_valid <= 1'b1;
                  own_d     <= data_wins;
                  if (data_wins) begin
                     bus_write  <= dreq_write;
                     bus_addr   <= dreq_addr;
                     bus_size   <= dreq_size;
                     bus_data   <= dreq_data;
                     bus_strobe <= dreq_strobe;
                     if (!ireq_valid)
                        dcnt <= 4'd0;
                     else if (dcnt != BURST_MAX)
                        dcnt <= dcnt + 4'd1;
                  end else begin
                     bus_write  <= 1'b0;
                     bus_addr   <= ireq_addr;
                     bus_size   <= 3'b010;
                     bus_data   <= 64'd0;
                     bus_strobe <= 8'd0;
                     dcnt       <= 4'd0;
                  end
               end
            end
            REQ: begin
               if (bus_ready) begin
                  bus_valid <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (bus_rvalid) begin
                  state <= DONE;
                  if (own_d) begin
                     dresp_ok   <= 1'b1;
                     dresp_data <= bus_write ? 64'd0 : bus_rdata;
                  end else begin
                     iresp_ok   <= 1'b1;
                     iresp_data <= bus_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0];
                  end
               end
            end
            DONE: begin
               // No arbitration here: requesters get a cycle to drop or replace their valid.
               iresp_ok   <= 1'b0;
               dresp_ok   <= 1'b0;
               iresp_data <= 32'd0;
               dresp_data <= 64'd0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;
   localparam int MAX = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ireq_valid = 1'b0;
   logic [63:0] ireq_addr = 64'd0;
   logic        iresp_ok;
   logic [31:0] iresp_data;
   logic        dreq_valid = 1'b0;
   logic        dreq_write = 1'b0;
   logic [63:0] dreq_addr = 64'd0;
   logic [2:0]  dreq_size = 3'd0;
   logic [63:0] dreq_data = 64'd0;
   logic [7:0]  dreq_strobe = 8'd0;
   logic        dresp_ok;
   logic [63:0] dresp_data;
   logic        bus_valid;
   logic        bus_write;
   logic [63:0] bus_addr;
   logic [2:0]  bus_size;
   logic [63:0] bus_data;
   logic [7:0]  bus_strobe;
   logic        bus_ready = 1'b0;
   logic        bus_rvalid = 1'b0;
   logic [63:0] bus_rdata = 64'd0;

   mem_arbiter #(.DATA_BURST_MAX(MAX)) dut (
      .clk(clk), .resetn(resetn),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_ok(iresp_ok), .iresp_data(iresp_data),
      .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
      .dreq_size(dreq_size), .dreq_data(dreq_data), .dreq_strobe(dreq_strobe),
      .dresp_ok(dresp_ok), .dresp_data(dresp_data),
      .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
      .bus_size(bus_size), .bus_data(bus_data), .bus_strobe(bus_strobe),
      .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
      end
   endtask

   // Reference model: one outstanding transaction, tracked through its lifecycle
   // (0 free, 1 offered on bus, 2 accepted, 3 reporting completion).
   int          m_phase = 0;
   bit          m_own_d = 1'b0;
   int          m_streak = 0;
   logic        m_write = 1'b0;
   logic [63:0] m_addr = 64'd0;
   logic [2:0]  m_size = 3'd0;
   logic [63:0] m_data = 64'd0;
   logic [7:0]  m_strobe = 8'd0;
   logic [63:0] m_cap = 64'd0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_phase = 0; m_own_d = 1'b0; m_streak = 0;
         m_write = 1'b0; m_addr = 64'd0; m_size = 3'd0; m_data = 64'd0; m_strobe = 8'd0;
      end else if (m_phase == 0) begin
         if (dreq_valid || ireq_valid) begin
            m_own_d = dreq_valid && !(ireq_valid && m_streak == MAX);
            if (m_own_d) begin
               m_write = dreq_write; m_addr = dreq_addr; m_size = dreq_size;
               m_data = dreq_data; m_strobe = dreq_strobe;
               m_streak = ireq_valid ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
            end else begin
               m_write = 1'b0; m_addr = ireq_addr; m_size = 3'b010;
               m_data = 64'd0; m_strobe = 8'd0;
               m_streak = 0;
            end
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (bus_ready) m_phase = 2;
      end else if (m_phase == 2) begin
         if (bus_rvalid) begin
            m_cap = bus_rdata;
            m_phase = 3;
         end
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (!resetn) begin
         chk("rst_bus_valid", bus_valid, 0);
         chk("rst_oks", {iresp_ok, dresp_ok}, 0);
         chk("rst_bus_addr", bus_addr, 0);
         chk("rst_bus_data", bus_data, 0);
         chk("rst_bus_ctrl", {bus_write, bus_size, bus_strobe}, 0);
         chk("rst_resp_data", dresp_data | {32'd0, iresp_data}, 0);
      end else begin
         chk("bus_valid", bus_valid, m_phase == 1);
         chk("iresp_ok", iresp_ok, m_phase == 3 && !m_own_d);
         chk("dresp_ok", dresp_ok, m_phase == 3 && m_own_d);
         chk("one_ok", iresp_ok & dresp_ok, 0);
         if (m_phase == 1 || m_phase == 2) begin
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_data", bus_data, m_data);
            chk("bus_ctrl", {bus_write, bus_size, bus_strobe}, {m_write, m_size, m_strobe});
         end
         if (m_phase == 3 && m_own_d)
            chk("dresp_data", dresp_data, m_write ? 64'd0 : m_cap);
         if (m_phase == 3 && !m_own_d)
            chk("iresp_data", iresp_data, m_addr[2] ? m_cap[63:32] : m_cap[31:0]);
      end
   end

   // Bus responder: optional ready stall, then rvalid the cycle after acceptance.
   bit          auto_rsp = 1'b1;
   int          stall_cfg = 0;
   int          stall_left = 0;
   bit          acc = 1'b0;
   logic [63:0] rdata_next = 64'd0;
   int          vcnt = 0;

   always @(negedge clk) begin
      if (auto_rsp) begin
         bus_ready = 1'b0;
         bus_rvalid = 1'b0;
         if (acc) begin
            bus_rvalid = 1'b1;
            bus_rdata = rdata_next;
            acc = 1'b0;
         end else if (bus_valid) begin
            if (stall_left > 0) stall_left--;
            else begin
               bus_ready = 1'b1;
               acc = 1'b1;
               stall_left = stall_cfg;
            end
         end
      end
      if (bus_valid) vcnt++;
   end

   string       glog;
   int          last_i_cyc, last_d_cyc;
   logic [31:0] last_idata;
   logic [63:0] last_ddata;

   task automatic run_until(input int n, input bit drop_i, input bit drop_d);
      int seen = 0;
      for (int k = 0; k < 200 && seen < n; k++) begin
         @(negedge clk);
         if (!auto_rsp) bus_rvalid = 1'b0;
         if (iresp_ok) begin
            glog = {glog, "I"}; seen++; last_i_cyc = cyc; last_idata = iresp_data;
            if (drop_i) ireq_valid = 1'b0;
         end
         if (dresp_ok) begin
            glog = {glog, "D"}; seen++; last_d_cyc = cyc; last_ddata = dresp_data;
            if (drop_d) dreq_valid = 1'b0;
         end
      end
      chk("ok_count", 64'(seen), 64'(n));
   endtask

   task automatic wait_valid();
      for (int k = 0; k < 20 && !bus_valid; k++) @(negedge clk);
      chk("wait_valid", bus_valid, 1);
   endtask

   task automatic set_dreq(input bit wr, input logic [63:0] a, input logic [2:0] sz,
                           input logic [63:0] d, input logic [7:0] st);
      dreq_valid = 1'b1; dreq_write = wr; dreq_addr = a; dreq_size = sz;
      dreq_data = d; dreq_strobe = st;
   endtask

   int c0;
   int oks;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_literal", {bus_valid, iresp_ok, dresp_ok}, 0);
      #2 resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Single fetch, upper word selected by addr[2].
      rdata_next = 64'h1111_2222_3333_4444;
      vcnt = 0; glog = "";
      ireq_valid = 1'b1; ireq_addr = 64'h8000_0004; c0 = cyc;
      run_until(1, 1, 1);
      chk("fetch_latency", 64'(last_i_cyc - c0), 3);
      chk("fetch_data", last_idata, 32'h1111_2222);
      chk("fetch_valid_cycles", 64'(vcnt), 1);
      chk_str("fetch_order", glog, "I");
      repeat (2) @(negedge clk);

      // Data write with a three-cycle ready stall.
      stall_cfg = 3; stall_left = 3; vcnt = 0; glog = "";
      rdata_next = 64'h5555_6666_7777_8888;
      set_dreq(1'b1, 64'h100, 3'b011, 64'hAABB_CCDD_0000_0000, 8'hF0); c0 = cyc;
      run_until(1, 1, 1);
      chk("write_valid_cycles", 64'(vcnt), 4);
      chk("write_resp_data", last_ddata, 0);
      chk("write_latency", 64'(last_d_cyc - c0), 6);
      stall_cfg = 0; stall_left = 0;
      repeat (2) @(negedge clk);

      // Simultaneous requests: data first, fetch right after.
      rdata_next = 64'hCAFE_F00D_1234_5678; glog = "";
      set_dreq(1'b0, 64'h200, 3'b011, 64'd0, 8'd0);
      ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
      run_until(2, 1, 1);
      chk_str("simul_order", glog, "DI");
      chk("simul_ddata", last_ddata, 64'hCAFE_F00D_1234_5678);
      chk("simul_idata", last_idata, 32'h1234_5678);
      repeat (2) @(negedge clk);

      // Starvation guard with both requesters held valid.
      glog = "";
      set_dreq(1'b0, 64'h208, 3'b011, 64'd0, 8'd0);
      ireq_valid = 1'b1; ireq_addr = 64'h8000_0010;
      run_until(10, 0, 0);
      ireq_valid = 1'b0; dreq_valid = 1'b0;
      chk_str("starve_order", glog, "DDDDIDDDDI");
      repeat (3) @(negedge clk);

      // Reset while waiting for the response; the late rvalid must be ignored.
      auto_rsp = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
      set_dreq(1'b0, 64'h300, 3'b011, 64'd0, 8'd0);
      wait_valid();
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      @(negedge clk);
      #2 resetn = 1'b0;
      dreq_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 resetn = 1'b1;
      @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      oks = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus_rvalid = 1'b0;
         if (iresp_ok || dresp_ok) oks++;
      end
      chk("post_reset_no_ok", 64'(oks), 0);
      auto_rsp = 1'b1;
      rdata_next = 64'h0BAD_F00D_ABCD_0123; glog = "";
      @(negedge clk);
      ireq_valid = 1'b1; ireq_addr = 64'h8000_0020; c0 = cyc;
      run_until(1, 1, 1);
      chk("post_reset_latency", 64'(last_i_cyc - c0), 3);
      chk("post_reset_idata", last_idata, 32'hABCD_0123);
      repeat (2) @(negedge clk);

      // Early rvalid while the request is still unaccepted.
      auto_rsp = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; vcnt = 0;
      set_dreq(1'b0, 64'h400, 3'b011, 64'd0, 8'd0);
      wait_valid();
      bus_rvalid = 1'b1; bus_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      @(negedge clk);
      bus_rvalid = 1'b0;
      @(negedge clk);
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h0123_4567_89AB_CDEF;
      run_until(1, 1, 1);
      chk("early_rvalid_data", last_ddata, 64'h0123_4567_89AB_CDEF);
      chk("early_valid_cycles", 64'(vcnt), 3);
      auto_rsp = 1'b1;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
